// File: rtl/dd_rtx_marker_multi_if.sv
// Handshake bundle between the incoming-event logic, the range marker
// and the flow-state writeback stage.
interface dd_rtx_marker_multi_if #(
    parameter int WIN_SIZE   = 128,
    parameter int WIN_IND_W  = $clog2(WIN_SIZE),
    parameter int SEQ_W      = 32,
    parameter int NUM_RANGES = 4,
    parameter int CNT_W      = $clog2(NUM_RANGES + 1)
);
    logic                        in_valid;
    logic                        in_ready;
    logic [CNT_W-1:0]            in_range_cnt;
    logic [NUM_RANGES*SEQ_W-1:0] in_rtx_start;
    logic [NUM_RANGES*SEQ_W-1:0] in_rtx_end;
    logic [SEQ_W-1:0]            in_wnd_start;
    logic [WIN_IND_W-1:0]        in_wnd_start_ind;
    logic [WIN_SIZE-1:0]         in_acked_wnd;
    logic [WIN_SIZE-1:0]         in_rtx_wnd;
    logic                        in_flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIN_SIZE-1:0]         rtx_wnd_out;
    logic [WIN_IND_W:0]          mark_cnt_out;
    logic [CNT_W-1:0]            drop_cnt_out;

    modport master (
        output in_valid, in_range_cnt, in_rtx_start, in_rtx_end,
        output in_wnd_start, in_wnd_start_ind, in_acked_wnd,
        output in_rtx_wnd, in_flush, out_ready,
        input  in_ready, out_valid, rtx_wnd_out,
        input  mark_cnt_out, drop_cnt_out
    );

    modport slave (
        input  in_valid, in_range_cnt, in_rtx_start, in_rtx_end,
        input  in_wnd_start, in_wnd_start_ind, in_acked_wnd,
        input  in_rtx_wnd, in_flush, out_ready,
        output in_ready, out_valid, rtx_wnd_out,
        output mark_cnt_out, drop_cnt_out
    );
endinterface

// File: rtl/dd_rtx_marker_multi.sv
// Multi-range retransmit-window marker: ORs one sequence range per cycle
// into the retransmit bitmap, wrapping and clipping to the window.
module dd_rtx_marker_multi #(
    parameter int WIN_SIZE   = 128,
    parameter int WIN_IND_W  = $clog2(WIN_SIZE),
    parameter int SEQ_W      = 32,
    parameter int NUM_RANGES = 4,
    parameter int CNT_W      = $clog2(NUM_RANGES + 1)
) (
    input logic                  clk,
    input logic                  rst_n,
    dd_rtx_marker_multi_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MARK, DONE} state_t;

    state_t                      state;
    logic [NUM_RANGES*SEQ_W-1:0] start_l;
    logic [NUM_RANGES*SEQ_W-1:0] end_l;
    logic [SEQ_W-1:0]            wnd_l;
    logic [WIN_IND_W-1:0]        ind_l;
    logic [WIN_SIZE-1:0]         acked_l;
    logic [WIN_SIZE-1:0]         rtx_l;
    logic [WIN_SIZE-1:0]         work;
    logic [CNT_W-1:0]            cnt_l;
    logic [CNT_W-1:0]            p;
    logic [CNT_W-1:0]            drop_cnt;
    logic [WIN_IND_W:0]          mark_cnt;
    logic                        out_valid;

    logic [CNT_W-1:0]            cnt_eff;
    logic [SEQ_W-1:0]            rs;
    logic [SEQ_W-1:0]            re;
    logic [SEQ_W-1:0]            off_s;
    logic [SEQ_W-1:0]            len;
    logic [SEQ_W:0]              off_e;
    logic                        empty;
    logic                        outside;
    logic [WIN_IND_W-1:0]        slot;
    logic [WIN_SIZE-1:0]         mask;
    logic [WIN_SIZE-1:0]         work_nxt;
    logic [WIN_IND_W:0]          pop;

    assign cnt_eff = (bus.in_range_cnt > CNT_W'(NUM_RANGES))
                   ? CNT_W'(NUM_RANGES) : bus.in_range_cnt;

    always_comb begin
        rs = '0;
        re = '0;
        for (int i = 0; i < NUM_RANGES; i++) begin
            if (p == CNT_W'(i)) begin
                rs = start_l[i*SEQ_W +: SEQ_W];
                re = end_l[i*SEQ_W +: SEQ_W];
            end
        end
    end

    // Offsets are modular, so a negative length shows up as a set MSB.
    always_comb begin
        off_s   = rs - wnd_l;
        len     = re - rs;
        empty   = (len == '0) | len[SEQ_W-1];
        outside = off_s >= SEQ_W'(WIN_SIZE);
        off_e   = {1'b0, off_s} + {1'b0, len};
        if (off_e > (SEQ_W+1)'(WIN_SIZE))
            off_e = (SEQ_W+1)'(WIN_SIZE);
    end

    always_comb begin
        mask = '0;
        slot = '0;
        for (int o = 0; o < WIN_SIZE; o++) begin
            slot = ind_l + WIN_IND_W'(o);
            if (!empty && !outside &&
                (SEQ_W+1)'(o) >= {1'b0, off_s} &&
                (SEQ_W+1)'(o) < off_e)
                mask[slot] = 1'b1;
        end
    end

    always_comb begin
        work_nxt = work | (mask & ~acked_l);
        pop      = '0;
        for (int o = 0; o < WIN_SIZE; o++)
            pop = pop + (WIN_IND_W+1)'(work_nxt[o] & ~rtx_l[o]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_l   <= '0;
            end_l     <= '0;
            wnd_l     <= '0;
            ind_l     <= '0;
            acked_l   <= '0;
            rtx_l     <= '0;
            work      <= '0;
            cnt_l     <= '0;
            p         <= '0;
            drop_cnt  <= '0;
            mark_cnt  <= '0;
            out_valid <= 1'b0;
        end else if (bus.in_flush) begin
            state     <= IDLE;
            work      <= '0;
            p         <= '0;
            drop_cnt  <= '0;
            mark_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        start_l  <= bus.in_rtx_start;
                        end_l    <= bus.in_rtx_end;
                        wnd_l    <= bus.in_wnd_start;
                        ind_l    <= bus.in_wnd_start_ind;
                        acked_l  <= bus.in_acked_wnd;
                        rtx_l    <= bus.in_rtx_wnd;
                        work     <= bus.in_rtx_wnd & ~bus.in_acked_wnd;
                        cnt_l    <= cnt_eff;
                        p        <= '0;
                        drop_cnt <= '0;
                        mark_cnt <= '0;
                        if (cnt_eff == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= MARK;
                        end
                    end
                end
                MARK: begin
                    work <= work_nxt;
                    p    <= p + CNT_W'(1);
                    if (!empty && outside)
                        drop_cnt <= drop_cnt + CNT_W'(1);
                    if (p + CNT_W'(1) == cnt_l) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        mark_cnt  <= pop;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state == IDLE) & rst_n;
    assign bus.out_valid    = out_valid;
    assign bus.rtx_wnd_out  = work;
    assign bus.mark_cnt_out = mark_cnt;
    assign bus.drop_cnt_out = drop_cnt;

endmodule

// File: tb/tb_dd_rtx_marker_multi.sv
// Bench for the multi-range retransmit marker: directed cases plus
// randomized events against a slot-by-slot reference model.
module tb_dd_rtx_marker_multi;

    localparam int W  = 16;
    localparam int SW = 32;
    localparam int NR = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dd_rtx_marker_multi_if #(.WIN_SIZE(W), .SEQ_W(SW), .NUM_RANGES(NR)) bus ();

    dd_rtx_marker_multi #(.WIN_SIZE(W), .SEQ_W(SW), .NUM_RANGES(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] st [NR];
    logic [31:0] en [NR];
    logic [31:0] ws;
    logic [3:0]  ind;
    logic [15:0] ack;
    logic [15:0] rtx;
    logic [2:0]  cnt;

    logic [15:0] ew;
    int          em;
    int          ed;
    int          er;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Walks every range slot by slot in sequence space.
    task automatic model();
        ew = rtx & ~ack;
        ed = 0;
        er = (int'(cnt) > NR) ? NR : int'(cnt);
        for (int r = 0; r < er; r++) begin
            logic [31:0] off;
            logic [31:0] len;
            off = st[r] - ws;
            len = en[r] - st[r];
            if (len == 0 || len >= 32'h8000_0000) continue;
            if (off >= 32'(W)) begin
                ed++;
                continue;
            end
            for (longint o = longint'(off);
                 o < longint'(off) + longint'(len) && o < W; o++) begin
                int s;
                s = (int'(ind) + int'(o)) % W;
                if (!ack[s]) ew[s] = 1'b1;
            end
        end
        em = $countones(ew & ~rtx);
    endtask

    task automatic scramble();
        bus.in_range_cnt     = 3'($urandom);
        bus.in_rtx_start     = {$urandom, $urandom, $urandom, $urandom};
        bus.in_rtx_end       = {$urandom, $urandom, $urandom, $urandom};
        bus.in_wnd_start     = $urandom;
        bus.in_wnd_start_ind = 4'($urandom);
        bus.in_acked_wnd     = 16'($urandom);
        bus.in_rtx_wnd       = 16'($urandom);
    endtask

    task automatic drive();
        bus.in_range_cnt     = cnt;
        bus.in_rtx_start     = {st[3], st[2], st[1], st[0]};
        bus.in_rtx_end       = {en[3], en[2], en[1], en[0]};
        bus.in_wnd_start     = ws;
        bus.in_wnd_start_ind = ind;
        bus.in_acked_wnd     = ack;
        bus.in_rtx_wnd       = rtx;
        bus.in_valid         = 1'b1;
    endtask

    task automatic clear_ranges();
        for (int i = 0; i < NR; i++) begin
            st[i] = $urandom;
            en[i] = $urandom;
        end
    endtask

    task automatic run_event(string tag, logic [15:0] xw, int xm,
                             int xd, int xl, bit hold);
        int lat;
        drive();
        check({tag, "_rdy"}, bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        scramble();
        check({tag, "_rdyfall"}, bus.in_ready, 0);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, xl);
        check({tag, "_wnd"}, bus.rtx_wnd_out, xw);
        check({tag, "_mark"}, bus.mark_cnt_out, xm);
        check({tag, "_drop"}, bus.drop_cnt_out, xd);
        if (hold) begin
            repeat (5) begin
                @(negedge clk);
                check({tag, "_hvld"}, bus.out_valid, 1);
                check({tag, "_hrdy"}, bus.in_ready, 0);
                check({tag, "_hwnd"}, bus.rtx_wnd_out, xw);
                check({tag, "_hmark"}, bus.mark_cnt_out, xm);
                check({tag, "_hdrop"}, bus.drop_cnt_out, xd);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_vldfall"}, bus.out_valid, 0);
        check({tag, "_rerdy"}, bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b0;
        scramble();
        #3;
        check("rst_vld", bus.out_valid, 0);
        check("rst_wnd", bus.rtx_wnd_out, 0);
        check("rst_mark", bus.mark_cnt_out, 0);
        check("rst_drop", bus.drop_cnt_out, 0);
        check("rst_rdy", bus.in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        clear_ranges();
        ws = 100; ind = 3; ack = 0; rtx = 0; cnt = 1;
        st[0] = 102; en[0] = 106;
        run_event("basic", 16'h01E0, 4, 0, 2, 1'b0);

        clear_ranges();
        ws = 100; ind = 14; ack = 0; rtx = 0; cnt = 1;
        st[0] = 100; en[0] = 104;
        run_event("wrap", 16'hC003, 4, 0, 2, 1'b0);

        clear_ranges();
        ws = 100; ind = 0; ack = 0; rtx = 0; cnt = 2;
        st[0] = 110; en[0] = 130;
        st[1] = 120; en[1] = 125;
        run_event("clip", 16'hFC00, 6, 1, 3, 1'b0);

        clear_ranges();
        ws = 32'hFFFF_FFFE; ind = 0; ack = 16'h0004; rtx = 16'h8004; cnt = 1;
        st[0] = 32'hFFFF_FFFF; en[0] = 32'h0000_0002;
        run_event("seqwrap", 16'h800A, 2, 0, 2, 1'b0);

        clear_ranges();
        ws = 100; ind = 5; ack = 16'h0011; rtx = 16'h00F3; cnt = 0;
        run_event("cnt0", 16'h00E2, 0, 0, 1, 1'b0);

        clear_ranges();
        cnt = 1; st[0] = 105; en[0] = 105;
        run_event("len0", 16'h00E2, 0, 0, 2, 1'b0);

        clear_ranges();
        cnt = 1; st[0] = 110; en[0] = 105;
        run_event("neglen", 16'h00E2, 0, 0, 2, 1'b0);

        clear_ranges();
        ws = 100; ind = 3; ack = 0; rtx = 0; cnt = 1;
        st[0] = 102; en[0] = 106;
        run_event("bp", 16'h01E0, 4, 0, 2, 1'b1);

        for (int n = 0; n < 40; n++) begin
            ws  = $urandom;
            ind = 4'($urandom);
            ack = 16'($urandom) & 16'($urandom);
            rtx = 16'($urandom);
            cnt = 3'($urandom);
            for (int i = 0; i < NR; i++) begin
                st[i] = ws + 32'($urandom_range(0, 24)) - 32'd4;
                if ($urandom_range(0, 7) == 0)
                    en[i] = st[i] - 32'($urandom_range(1, 5));
                else
                    en[i] = st[i] + 32'($urandom_range(0, 20));
            end
            model();
            run_event($sformatf("rnd%0d", n), ew, em, ed, er + 1, n[2]);
        end

        clear_ranges();
        ws = 100; ind = 0; ack = 0; rtx = 16'h00FF; cnt = 3;
        drive();
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_flush = 1'b1;
        @(negedge clk);
        bus.in_flush = 1'b0;
        check("flush_vld", bus.out_valid, 0);
        check("flush_rdy", bus.in_ready, 1);
        repeat (5) @(negedge clk);
        check("flush_quiet", bus.out_valid, 0);

        clear_ranges();
        ws = 100; ind = 0; ack = 0; rtx = 16'h00FF; cnt = 4;
        drive();
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("prerst_wnd", bus.rtx_wnd_out, 16'h00FF);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_vld", bus.out_valid, 0);
        check("midrst_wnd", bus.rtx_wnd_out, 0);
        check("midrst_mark", bus.mark_cnt_out, 0);
        check("midrst_drop", bus.drop_cnt_out, 0);
        check("midrst_rdy", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_vld", bus.out_valid, 0);
        check("postrst_rdy", bus.in_ready, 1);

        clear_ranges();
        ws = 100; ind = 14; ack = 0; rtx = 0; cnt = 1;
        st[0] = 100; en[0] = 104;
        run_event("after", 16'hC003, 4, 0, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
